// File: rtl/multi_pass_controller_if.sv
// Handshake bundle between the multi-pass controller and its engine/write side.
// master = controller, slave = engine/environment.
interface multi_pass_if #(
    parameter int unsigned CNT_W = 2
);
    logic             start;
    logic             abort;
    logic             eng_done;
    logic             wr_ack;
    logic             ldx;
    logic             ldu;
    logic             eng_start;
    logic             wr_req;
    logic             shl;
    logic             done;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] pass_idx;

    modport master (
        input  start, abort, eng_done, wr_ack,
        output ldx, ldu, eng_start, wr_req, shl, done, busy, timeout_err, pass_idx
    );

    modport slave (
        output start, abort, eng_done, wr_ack,
        input  ldx, ldu, eng_start, wr_req, shl, done, busy, timeout_err, pass_idx
    );
endinterface

// File: rtl/multi_pass_controller.sv
// Sequences an external compute engine over PASSES iterations with optional write
// handshake, abort and a CALC-phase watchdog.
module multi_pass_controller #(
    parameter int unsigned PASSES   = 4,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned ACK_MODE = 0,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned TMR_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    multi_pass_if.master bus
);
    localparam int unsigned LAST_IDX = PASSES - 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          ACK_EN   = (ACK_MODE != 0);
    localparam bit          TMO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        CALC,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pass_idx;
    logic [CNT_W-1:0] pass_idx_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;

    logic ld_q;
    logic eng_start_q;
    logic wr_req_q;
    logic done_q;
    logic busy_q;
    logic tmo_err_q;

    logic accepted_c;
    logic last_pass_c;
    logic tmo_hit_c;

    assign accepted_c  = !ACK_EN || bus.wr_ack;
    assign last_pass_c = (pass_idx == CNT_W'(LAST_IDX));
    assign tmo_hit_c   = TMO_EN && (timer == TMR_W'(TMO_LAST));

    // Next-state, pass counter and watchdog timer
    always_comb begin
        state_nxt    = state;
        pass_idx_nxt = pass_idx;
        timer_nxt    = timer;
        case (state)
            IDLE: begin
                pass_idx_nxt = '0;
                timer_nxt    = '0;
                if (bus.start) state_nxt = WAIT;
            end
            WAIT: begin
                if (!bus.start) state_nxt = START;
            end
            START: begin
                timer_nxt = '0;
                state_nxt = CALC;
            end
            CALC: begin
                if (bus.eng_done) begin
                    state_nxt = WRITE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                    if (tmo_hit_c) state_nxt = ERR;
                end
            end
            WRITE: begin
                if (accepted_c) begin
                    if (last_pass_c) begin
                        state_nxt = DONE;
                    end else begin
                        pass_idx_nxt = pass_idx + CNT_W'(1);
                        state_nxt    = START;
                    end
                end
            end
            DONE: begin
                pass_idx_nxt = '0;
                state_nxt    = IDLE;
            end
            ERR: begin
                if (bus.start) begin
                    pass_idx_nxt = '0;
                    timer_nxt    = '0;
                    state_nxt    = WAIT;
                end
            end
            default: begin
                pass_idx_nxt = '0;
                timer_nxt    = '0;
                state_nxt    = IDLE;
            end
        endcase
        // Abort overrides any transition, including eng_done and wr_ack in the same cycle
        if (bus.abort && (state != IDLE)) begin
            state_nxt    = IDLE;
            pass_idx_nxt = '0;
            timer_nxt    = '0;
        end
    end

    // State register; Moore outputs are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pass_idx    <= '0;
            timer       <= '0;
            ld_q        <= 1'b0;
            eng_start_q <= 1'b0;
            wr_req_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pass_idx    <= pass_idx_nxt;
            timer       <= timer_nxt;
            ld_q        <= (state_nxt == WAIT);
            eng_start_q <= (state_nxt == START);
            wr_req_q    <= (state_nxt == WRITE);
            done_q      <= (state_nxt == DONE);
            busy_q      <= (state_nxt == WAIT) || (state_nxt == START) ||
                           (state_nxt == CALC) || (state_nxt == WRITE);
            tmo_err_q   <= (state_nxt == ERR);
        end
    end

    assign bus.ldx         = ld_q;
    assign bus.ldu         = ld_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.wr_req      = wr_req_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tmo_err_q;
    assign bus.pass_idx    = pass_idx;

    // Shift fires only on a write that is actually taken (not squashed by abort/reset)
    assign bus.shl = (state == WRITE) && accepted_c && !bus.abort && !rst;
endmodule

// File: tb/tb_multi_pass_controller.sv
// Randomised bench for multi_pass_controller: three configurations share stimulus,
// one is selected per scenario and compared against pass/latency arithmetic.
module tb_multi_pass_controller;
    logic clk = 1'b0;
    logic rst;
    logic start, abort, eng_done, wr_ack;

    int checks   = 0;
    int failures = 0;
    int calc_dly[4];
    int ack_dly[4];

    typedef struct packed {
        logic       ldx;
        logic       ldu;
        logic       eng_start;
        logic       wr_req;
        logic       shl;
        logic       done;
        logic       busy;
        logic       timeout_err;
        logic [7:0] pass_idx;
    } obs_t;

    always #5 clk = ~clk;

    multi_pass_if #(.CNT_W(2)) if0 ();
    multi_pass_if #(.CNT_W(2)) if1 ();
    multi_pass_if #(.CNT_W(1)) if2 ();

    assign if0.start = start; assign if0.abort = abort; assign if0.eng_done = eng_done; assign if0.wr_ack = wr_ack;
    assign if1.start = start; assign if1.abort = abort; assign if1.eng_done = eng_done; assign if1.wr_ack = wr_ack;
    assign if2.start = start; assign if2.abort = abort; assign if2.eng_done = eng_done; assign if2.wr_ack = wr_ack;

    multi_pass_controller #(.PASSES(4), .CNT_W(2), .ACK_MODE(0), .TIMEOUT(0), .TMR_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    multi_pass_controller #(.PASSES(4), .CNT_W(2), .ACK_MODE(1), .TIMEOUT(8), .TMR_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    multi_pass_controller #(.PASSES(1), .CNT_W(1), .ACK_MODE(0), .TIMEOUT(0), .TMR_W(8))
        dut2 (.clk(clk), .rst(rst), .bus(if2.master));

    obs_t ob0, ob1, ob2;
    assign ob0 = {if0.ldx, if0.ldu, if0.eng_start, if0.wr_req, if0.shl, if0.done, if0.busy, if0.timeout_err, 8'(if0.pass_idx)};
    assign ob1 = {if1.ldx, if1.ldu, if1.eng_start, if1.wr_req, if1.shl, if1.done, if1.busy, if1.timeout_err, 8'(if1.pass_idx)};
    assign ob2 = {if2.ldx, if2.ldu, if2.eng_start, if2.wr_req, if2.shl, if2.done, if2.busy, if2.timeout_err, 8'(if2.pass_idx)};

    function automatic obs_t get_obs(input int sel);
        case (sel)
            0:       return ob0;
            1:       return ob1;
            default: return ob2;
        endcase
    endfunction

    function automatic int passes_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    function automatic bit in_calc(input obs_t o);
        return o.busy && !o.ldx && !o.eng_start && !o.wr_req;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; eng_done = 1'b0; wr_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic randomize_delays(input int calc_max, input int ack_max);
        for (int p = 0; p < 4; p++) begin
            calc_dly[p] = int'($urandom_range(0, calc_max));
            ack_dly[p]  = int'($urandom_range(0, ack_max));
        end
    endtask

    // One complete run from IDLE (or ERR), responding to the DUT like an engine would
    task automatic do_run(input int sel, input int hold, input bit from_err, input string tag);
        int passes, exp_lat, exp_wr, first_start, done_at;
        int n_start, n_shl, n_wr, n_ld, calc_cnt, wr_cnt, idx;
        bit ackm, exp_shl;
        obs_t o;
        passes = passes_of(sel); ackm = (sel == 1);
        exp_lat = 0; exp_wr = 0; first_start = -1; done_at = -1;
        n_start = 0; n_shl = 0; n_wr = 0; n_ld = 0; calc_cnt = 0; wr_cnt = 0;
        for (int p = 0; p < passes; p++) begin
            exp_wr  += ackm ? ack_dly[p] + 1 : 1;
            exp_lat += 2 + calc_dly[p] + (ackm ? ack_dly[p] + 1 : 1);
        end
        for (int k = 0; k < 300 && done_at < 0; k++) begin
            @(negedge clk);
            o = get_obs(sel);
            if (k == 0) begin
                checks++;
                if (o.busy !== 1'b0 || o.timeout_err !== from_err || (!from_err && o.pass_idx !== 8'd0)) begin
                    failures++;
                    $display("FAIL %s entry: busy=%b err=%b idx=%0d, want busy=0 err=%b idx=0", tag, o.busy, o.timeout_err, o.pass_idx, from_err);
                end
            end else begin
                checks++;
                if (o.timeout_err !== 1'b0) begin
                    failures++;
                    $display("FAIL %s err_flag cyc%0d: got %b want 0", tag, k, o.timeout_err);
                end
            end
            if (o.ldx) n_ld++;
            if (o.eng_start) begin
                if (first_start < 0) first_start = k;
                checks++;
                if (o.pass_idx !== 8'(n_start)) begin
                    failures++;
                    $display("FAIL %s start_idx: got %0d want %0d", tag, o.pass_idx, n_start);
                end
                n_start++; calc_cnt = 0; wr_cnt = 0;
            end
            idx = (n_start > 0) ? ((n_start > 4) ? 3 : n_start - 1) : 0;
            start = (k < hold);
            if (in_calc(o)) begin
                eng_done = (calc_cnt == calc_dly[idx]);
                calc_cnt++;
            end else begin
                eng_done = 1'($urandom_range(0, 1));
            end
            if (o.wr_req) begin
                wr_ack = ackm ? (wr_cnt == ack_dly[idx]) : 1'($urandom_range(0, 1));
                wr_cnt++; n_wr++;
                checks++;
                if (o.pass_idx !== 8'(idx) || o.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s write_idx: got idx=%0d busy=%b want idx=%0d busy=1", tag, o.pass_idx, o.busy, idx);
                end
            end else begin
                wr_ack = 1'($urandom_range(0, 1));
            end
            #1;
            o = get_obs(sel);
            exp_shl = o.wr_req && (!ackm || wr_ack);
            checks++;
            if (o.shl !== exp_shl) begin
                failures++;
                $display("FAIL %s shl cyc%0d: got %b want %b", tag, k, o.shl, exp_shl);
            end
            if (o.shl) n_shl++;
            if (o.done) begin
                done_at = k;
                checks++;
                if (o.busy !== 1'b0 || o.pass_idx !== 8'(passes - 1)) begin
                    failures++;
                    $display("FAIL %s done_state: busy=%b idx=%0d want busy=0 idx=%0d", tag, o.busy, o.pass_idx, passes - 1);
                end
            end
        end
        start = 1'b0; eng_done = 1'b0; wr_ack = 1'b0;
        checks++;
        if (done_at < 0 || done_at - first_start !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d (done seen=%0d)", tag, done_at - first_start, exp_lat, done_at >= 0);
        end
        checks++;
        if (n_start !== passes || n_shl !== passes || n_wr !== exp_wr || n_ld !== hold) begin
            failures++;
            $display("FAIL %s counts: starts=%0d shl=%0d wr=%0d ld=%0d want %0d %0d %0d %0d",
                     tag, n_start, n_shl, n_wr, n_ld, passes, passes, exp_wr, hold);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; abort = 1'b0; eng_done = 1'b1; wr_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; eng_done = 1'b0; wr_ack = 1'b0;
        for (int s = 0; s < 3; s++) begin
            o = get_obs(s);
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %h want 0", s, o);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_run();
        apply_reset();
        for (int p = 0; p < 4; p++) begin calc_dly[p] = 0; ack_dly[p] = 0; end
        do_run(0, 2, 1'b0, "basic");
    endtask

    task automatic test_back_to_back();
        do_run(0, 2, 1'b0, "rerun");
        randomize_delays(3, 0);
        do_run(0, 1, 1'b0, "rerun_rand");
    endtask

    task automatic test_ack_mode();
        apply_reset();
        randomize_delays(4, 2);
        ack_dly[1] = 3;
        do_run(1, 2, 1'b0, "ack_mode");
    endtask

    task automatic test_timeout();
        obs_t o;
        int calc_seen;
        bit seen;
        apply_reset();
        calc_seen = 0; seen = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            o = get_obs(1);
            if (o.timeout_err) seen = 1'b1;
            else if (in_calc(o)) calc_seen++;
        end
        checks++;
        if (!seen || calc_seen !== 8 || o.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_entry: seen=%b calc_cycles=%0d busy=%b want 1 8 0", seen, calc_seen, o.busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            eng_done = 1'($urandom_range(0, 1));
            wr_ack   = 1'($urandom_range(0, 1));
            o = get_obs(1);
            checks++;
            if (o.timeout_err !== 1'b1 || o.busy !== 1'b0) begin
                failures++;
                $display("FAIL timeout_sticky: err=%b busy=%b want 1 0", o.timeout_err, o.busy);
            end
        end
        eng_done = 1'b0; wr_ack = 1'b0;
        randomize_delays(6, 2);
        calc_dly[0] = 7;
        do_run(1, 1, 1'b1, "after_err");
    endtask

    task automatic test_abort();
        obs_t o;
        bit hit;
        apply_reset();
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            o = get_obs(0);
            start = (k == 0);
            eng_done = in_calc(o);
            if (in_calc(o) && o.pass_idx == 8'd2) begin
                hit = 1'b1; abort = 1'b1; eng_done = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0; eng_done = 1'b0;
        o = get_obs(0);
        checks++;
        if (!hit || o.busy !== 1'b0 || o.wr_req !== 1'b0 || o.done !== 1'b0 || o.pass_idx !== 8'd0 || o.shl !== 1'b0) begin
            failures++;
            $display("FAIL abort_calc: hit=%b busy=%b wr=%b done=%b idx=%0d shl=%b want 1 0 0 0 0 0",
                     hit, o.busy, o.wr_req, o.done, o.pass_idx, o.shl);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = get_obs(0);
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL abort_idle: got %h want 0", o);
            end
        end
        // Abort together with wr_ack during a handshaked write squashes the shift
        apply_reset();
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            o = get_obs(1);
            start = (k == 0);
            eng_done = in_calc(o);
            if (o.wr_req) begin
                hit = 1'b1; abort = 1'b1; wr_ack = 1'b1;
                #1;
                o = get_obs(1);
                checks++;
                if (o.shl !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_write_shl: got %b want 0", o.shl);
                end
            end
        end
        @(negedge clk);
        abort = 1'b0; wr_ack = 1'b0; eng_done = 1'b0;
        o = get_obs(1);
        checks++;
        if (!hit || o !== '0) begin
            failures++;
            $display("FAIL abort_write_after: hit=%b got %h want 0", hit, o);
        end
    endtask

    task automatic test_reset_in_write();
        obs_t o;
        bit hit;
        apply_reset();
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            o = get_obs(1);
            start = (k == 0);
            eng_done = in_calc(o);
            wr_ack = o.wr_req;
            if (o.wr_req && o.pass_idx == 8'd1) begin
                hit = 1'b1; rst = 1'b1; wr_ack = 1'b1;
                #1;
                o = get_obs(1);
                checks++;
                if (o.shl !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_write_shl: got %b want 0", o.shl);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; wr_ack = 1'b0; eng_done = 1'b0;
        o = get_obs(1);
        checks++;
        if (!hit || o !== '0) begin
            failures++;
            $display("FAIL reset_write_after: hit=%b got %h want 0", hit, o);
        end
    endtask

    task automatic test_random_runs();
        int sel;
        apply_reset();
        for (int it = 0; it < 12; it++) begin
            sel = int'($urandom_range(0, 2));
            randomize_delays(6, 4);
            do_run(sel, int'($urandom_range(1, 3)), 1'b0, $sformatf("rand%0d_dut%0d", it, sel));
            apply_reset();
        end
    endtask

    task automatic test_single_pass();
        apply_reset();
        randomize_delays(5, 0);
        do_run(2, 1, 1'b0, "single_pass");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; eng_done = 1'b0; wr_ack = 1'b0;
        test_reset();
        test_basic_run();
        test_back_to_back();
        test_ack_mode();
        test_timeout();
        test_abort();
        test_reset_in_write();
        test_single_pass();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
